slave_spi_rx: RTL and testbench
===============================

# slave_spi_rx

Serial-to-parallel receive stage for one port of a one-dimensional interconnect node. It samples a neighbour's serial link (frame select, serial clock, data) and assembles 32-bit instruction words. It buffers them in a small FIFO and presents them to the node's receiver queue as a data word plus a level "check" signal. One instance sits in front of each of the self, left and right inputs of the node.

## Interface

Parameters:
- `WIDTH`, 32: bits per word; the word is shifted in MSB first.
- `DEPTH`, 4: FIFO depth in words; must be a power of two, ≥ 2.

Ports:
- `clk`, input, 1: node clock; all state is on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `ser_cs`, input, 1: frame select from the upstream master; high means a frame is in progress. Asynchronous to `clk`.
- `ser_sclk`, input, 1: serial clock from the upstream master; data is valid on its rising edge. Asynchronous to `clk`.
- `ser_mosi`, input, 1: serial data. Asynchronous to `clk`.
- `out_data`, output, WIDTH: word at the FIFO head; holds its value while `out_cs` is high.
- `out_cs`, output, 1: high while the FIFO is non-empty; feeds the receiver queue's check input.
- `out_ready`, input, 1: consumer accept; pops the head on any cycle where `out_cs && out_ready`.
- `fill`, output, log2(DEPTH)+1: number of words held.
- `overflow`, output, 1: sticky; set when a completed word is dropped because the FIFO is full.
- `frame_err`, output, 1: sticky; set when `ser_cs` falls with 1 to WIDTH-1 bits received.
- `clear_err`, input, 1: synchronous clear of `overflow` and `frame_err`.

## Operation

- Synchronisation:
  - `ser_cs`, `ser_sclk` and `ser_mosi` each pass through a 2-flop synchroniser, followed by a third history flop.
  - `rise` = sync2 & ~sync3 on `ser_sclk`.
  - `cs_s` is sync2 of `ser_cs`.
  - `mosi_s` is sync2 of `ser_mosi`; it is equally delayed, so it aligns with `rise`.
- FSM states:
  - IDLE: `bitcnt` = 0. When `cs_s` is 1, go to SHIFT.
  - SHIFT: on `rise`, `shreg` ← {shreg[WIDTH-2:0], mosi_s} and `bitcnt`++. When `bitcnt` reaches WIDTH, raise the one-cycle `push` and go to WAIT_END. If `cs_s` falls first, set `frame_err` when `bitcnt` > 0, then go to IDLE. A CS pulse with no bits is silently ignored.
  - WAIT_END: ignore further `rise` edges; extra bits are discarded without error. When `cs_s` is 0, go to IDLE.
- FIFO:
  - `push` writes `shreg` when not full. If the FIFO is full, the word is dropped and `overflow` is set.
  - A pop happens when `out_cs && out_ready`.
  - A simultaneous push and pop when full is legal: the pop frees the slot, so there is no overflow.
  - A simultaneous push and pop when empty is not possible, because `out_cs` is 0.
  - Pointers wrap modulo DEPTH. `fill` = wr_ptr − rd_ptr, using one extra pointer bit.
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - A frame in progress is abandoned. If `ser_cs` is still high after reset, the frame is treated as new from its next bit. The bench must not expect recovery of that word.
- `clear_err` takes priority over a same-cycle set.

## Timing

- Upstream constraint: the `ser_sclk` high and low phases must each be ≥ 3 `clk` periods, and `ser_cs` must be stable for ≥ 3 `clk` periods around the first and last edges.
- Latency: if the clk edge that first samples the last `ser_sclk` high is edge k, then `rise` occurs at k+2, `push` at k+3, and `out_cs`/`out_data` are visible after k+4 (FIFO previously empty).
- `out_data` is registered FIFO-head output (show-ahead). After a pop, the next word or `out_cs`=0 is visible on the following cycle.
- Reset values: `out_data`=0, `out_cs`=0, `fill`=0, `overflow`=0, `frame_err`=0.

## Structure

- Shared package `spi_link_pkg`:
  - FSM state enum (IDLE, SHIFT, WAIT_END);
  - `WORD_W`=32;
  - the sclk minimum-phase constant `SCLK_MIN_PHASE`=3, for bench use.
- Sub-module `sync_fifo` (WIDTH, DEPTH; push/pop/full/empty/fill). It is reused later on the transmit side.
- The top level holds the synchronisers, edge detect, FSM, shift register and sticky flags.

## Test plan

- One frame of 0xDEADBEEF, MSB first, with sclk phase = 4 clk → `out_cs` rises 4 edges after the last bit is sampled, `out_data`=0xDEADBEEF, `fill`=1. Then `out_ready`=1 for one cycle → `out_cs`=0, `fill`=0.
- Five back-to-back frames (0x1, 0x2, 0x3, 0x4, 0x5) with `out_ready`=0 and DEPTH=4 → `fill`=4 and `overflow`=1. Pops then return 0x1..0x4 in order, and 0x5 is lost.
- `ser_cs` drops after 17 bits → `frame_err`=1 and nothing is pushed. The next full frame 0xA5A5A5A5 is received correctly. `clear_err` pulse → `frame_err`=0.
- FIFO full while the last bit of a new word arrives with `out_ready`=1 in the `push` cycle → no overflow, `fill` stays 4, and the new word is last in order.
- A frame of 40 bits → the word is built from the first 32 bits only, with no error, and a single push.
- `reset` asserted mid-frame at bit 10, released with `ser_cs` still high, followed by 32 more bits → all outputs 0 during reset, then exactly one word from the 32 post-reset bits.

Source files
------------

// File: rtl/spi_link_pkg.sv
// Shared definitions for the serial inter-node link.
// Used by the receive stage, its FIFO and benches.
package spi_link_pkg;

  localparam int WORD_W = 32;

  // Minimum sclk high/low phase in clk periods
  localparam int SCLK_MIN_PHASE = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small show-ahead FIFO with registered head output.
// A pushed word reaches the head one cycle after its write.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             pop_ok;
  logic             wr_ok;

  assign cnt    = wr_q - rd_q;
  assign full   = (cnt == FULL_CNT);
  assign empty  = (cnt == '0);
  assign fill   = cnt;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

  // A pop only counts while a head word is shown; a full FIFO
  // accepts a push when the same cycle frees a slot.
  assign pop_ok = pop & rvalid_q;
  assign wr_ok  = push & (~full | pop_ok);

  // Pointer and head-register next state
  always_comb begin
    wr_d     = wr_q + {{AW{1'b0}}, wr_ok};
    rd_d     = rd_q + {{AW{1'b0}}, pop_ok};
    rvalid_d = (cnt - {{AW{1'b0}}, pop_ok}) != '0;
    rdata_d  = rvalid_d ? mem_q[rd_d[AW-1:0]] : rdata_q;
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  // Pointers and registered head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: rtl/slave_spi_rx.sv
// Serial link receiver: synchronise, deserialise MSB first,
// and queue completed words for the node receiver.
module slave_spi_rx
  import spi_link_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ser_cs,
  input  logic                   ser_sclk,
  input  logic                   ser_mosi,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_cs,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
  output logic                   frame_err,
  input  logic                   clear_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2:0]       sclk_q;
  logic [1:0]       cs_q;
  logic [1:0]       mosi_q;
  logic             rise, cs_s, mosi_s;

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             push_q, push_d;
  logic             ferr_set;
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;

  logic             full, empty, pop;

  // Two-flop synchronisers, plus sclk history for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], ser_sclk};
      cs_q   <= {cs_q[0], ser_cs};
      mosi_q <= {mosi_q[0], ser_mosi};
    end
  end

  assign rise   = sclk_q[1] & ~sclk_q[2];
  assign cs_s   = cs_q[1];
  assign mosi_s = mosi_q[1];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cs_s) state_d = SHIFT;
      SHIFT: begin
        if (!cs_s)
          state_d = IDLE;
        else if (rise && bitcnt_q == LAST)
          state_d = WAIT_END;
      end
      WAIT_END: if (!cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: shifting, bit count, push and framing error
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      SHIFT: begin
        if (!cs_s) begin
          ferr_set = (bitcnt_q != '0);
          bitcnt_d = '0;
        end else if (rise) begin
          shreg_d  = {shreg_q[WIDTH-2:0], mosi_s};
          bitcnt_d = bitcnt_q + CW'(1);
          push_d   = (bitcnt_q == LAST);
        end
      end
      default: bitcnt_d = '0;
    endcase
  end

  // Sticky flags; a clear wins over a same-cycle set
  always_comb begin
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    if (clear_err) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      if (push_q && full && !pop) overflow_d = 1'b1;
      if (ferr_set) frame_err_d = 1'b1;
    end
  end

  // Datapath and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      push_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      push_q      <= push_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pop       = out_cs & out_ready;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_q),
    .wdata  (shreg_q),
    .pop    (pop),
    .rdata  (out_data),
    .rvalid (out_cs),
    .full   (full),
    .empty  (empty),
    .fill   (fill)
  );

  logic unused_empty;
  assign unused_empty = empty;

endmodule

// File: tb/tb_slave_spi_rx.sv
// Directed bench for slave_spi_rx.
// Serial frames are driven with a 4-clk sclk phase.
module tb_slave_spi_rx;
  import spi_link_pkg::*;

  localparam int PH = SCLK_MIN_PHASE + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ser_cs = 1'b0;
  logic        ser_sclk = 1'b0;
  logic        ser_mosi = 1'b0;
  logic [31:0] out_data;
  logic        out_cs;
  logic        out_ready = 1'b0;
  logic [2:0]  fill;
  logic        overflow;
  logic        frame_err;
  logic        clear_err = 1'b0;

  int total = 0;
  int bad = 0;

  slave_spi_rx #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_cs    (ser_cs),
    .ser_sclk  (ser_sclk),
    .ser_mosi  (ser_mosi),
    .out_data  (out_data),
    .out_cs    (out_cs),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clear_err (clear_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          nbits;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ser_mosi = d[i];
      ser_sclk = 1'b0;
      tick(PH);
      ser_sclk = 1'b1;
      tick(PH);
    end
  endtask

  task automatic end_frame();
    ser_sclk = 1'b0;
    tick(PH);
    ser_cs = 1'b0;
    tick(PH);
  endtask

  task automatic frame(input logic [63:0] d, input int n);
    ser_cs = 1'b1;
    tick(PH);
    shift_bits(d, n);
    end_frame();
  endtask

  // All bits but the last; caller drives the last rising edge
  task automatic frame_head(input logic [31:0] d);
    ser_cs = 1'b1;
    tick(PH);
    shift_bits(64'(d >> 1), 31);
    ser_mosi = d[0];
    ser_sclk = 1'b0;
    tick(PH);
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic clr();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h12345678, 32, 1'b1, 32'h12345678, 1'b0};
    vecs[1] = '{64'hFFFFFFFF, 32, 1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{64'h00000000, 32, 1'b1, 32'h00000000, 1'b0};
    vecs[3] = '{64'h80000001, 32, 1'b1, 32'h80000001, 1'b0};
    vecs[4] = '{64'hC3C3C3C399, 40, 1'b1, 32'hC3C3C3C3, 1'b0};
    vecs[5] = '{64'h1ABCD, 17, 1'b0, 32'h0, 1'b1};

    tick(3);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_cs", 64'(out_cs), 0);
    reset = 1'b0;
    tick(2);
    chk("rst_fill", 64'(fill), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_ferr", 64'(frame_err), 0);

    // Single frame with exact latency of the head output
    frame_head(32'hDEADBEEF);
    ser_sclk = 1'b1;
    tick(4);
    chk("lat_cs_early", 64'(out_cs), 0);
    chk("lat_fill", 64'(fill), 1);
    tick(1);
    chk("lat_cs", 64'(out_cs), 1);
    chk("lat_data", 64'(out_data), 64'hDEADBEEF);
    end_frame();
    chk("t1_fill", 64'(fill), 1);
    pop1();
    chk("t1_pop_cs", 64'(out_cs), 0);
    chk("t1_pop_fill", 64'(fill), 0);

    // Table of single frames into an empty FIFO
    for (int v = 0; v < 6; v++) begin
      frame(vecs[v].data, vecs[v].nbits);
      chk($sformatf("v%0d_cs", v), 64'(out_cs), 64'(vecs[v].exp_valid));
      if (vecs[v].exp_valid)
        chk($sformatf("v%0d_data", v), 64'(out_data),
            64'(vecs[v].exp_data));
      chk($sformatf("v%0d_fill", v), 64'(fill), 64'(vecs[v].exp_valid));
      chk($sformatf("v%0d_ferr", v), 64'(frame_err),
          64'(vecs[v].exp_ferr));
      if (out_cs) pop1();
      clr();
      chk($sformatf("v%0d_fill0", v), 64'(fill), 0);
      chk($sformatf("v%0d_ferr0", v), 64'(frame_err), 0);
    end

    // Five words into a four-deep FIFO
    for (int i = 1; i <= 5; i++) frame(64'(i), 32);
    chk("ovf_fill", 64'(fill), 4);
    chk("ovf_flag", 64'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_cs%0d", i), 64'(out_cs), 1);
      chk($sformatf("ovf_word%0d", i), 64'(out_data), 64'(i));
      pop1();
    end
    chk("ovf_empty", 64'(out_cs), 0);
    chk("ovf_fill0", 64'(fill), 0);
    clr();
    chk("ovf_clr", 64'(overflow), 0);

    // Short frame, then a good one, then clear
    frame(64'h1F0F0, 17);
    chk("fe_flag", 64'(frame_err), 1);
    chk("fe_fill", 64'(fill), 0);
    chk("fe_cs", 64'(out_cs), 0);
    frame(64'hA5A5A5A5, 32);
    chk("fe_next", 64'(out_data), 64'hA5A5A5A5);
    chk("fe_next_fill", 64'(fill), 1);
    chk("fe_sticky", 64'(frame_err), 1);
    pop1();
    clr();
    chk("fe_clr", 64'(frame_err), 0);

    // Push into a full FIFO in the same cycle as a pop
    for (int i = 1; i <= 4; i++) frame(64'(i * 32'h11), 32);
    chk("fp_fill_pre", 64'(fill), 4);
    frame_head(32'h55);
    ser_sclk = 1'b1;
    tick(3);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("fp_fill", 64'(fill), 4);
    end_frame();
    chk("fp_ovf", 64'(overflow), 0);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("fp_word%0d", i), 64'(out_data), 64'(i * 32'h11));
      pop1();
    end
    chk("fp_empty", 64'(out_cs), 0);

    // Reset in the middle of a frame with a word queued
    frame(64'h77, 32);
    chk("rs_pre_cs", 64'(out_cs), 1);
    ser_cs = 1'b1;
    tick(PH);
    shift_bits(64'h3FF, 10);
    ser_sclk = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    chk("rs_data", 64'(out_data), 0);
    chk("rs_cs", 64'(out_cs), 0);
    chk("rs_fill", 64'(fill), 0);
    chk("rs_ovf", 64'(overflow), 0);
    chk("rs_ferr", 64'(frame_err), 0);
    reset = 1'b0;
    tick(3);
    shift_bits(64'h3C3CF00F, 32);
    end_frame();
    chk("rs_word_cs", 64'(out_cs), 1);
    chk("rs_word", 64'(out_data), 64'h3C3CF00F);
    chk("rs_word_fill", 64'(fill), 1);
    chk("rs_word_ferr", 64'(frame_err), 0);
    pop1();
    chk("rs_end_fill", 64'(fill), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
